weyl_sng_seq: RTL and testbench

- Sequential, multi-channel successor to the combinational Weyl SNG.
- Accepts CH signed quantised operands per transaction and computes a per-channel quota. It fills each channel's BITSTREAM-bit stochastic word over several cycles, placing LANES Weyl-sequence bits per cycle per channel.
- Presents the finished words on a valid/ready output.
- Sits between the quantised activation/weight source and the stochastic compute array.

---
 rtl/weyl_sng_seq_if.sv | 26 ++
 rtl/weyl_sng_seq.sv | 121 ++++++++++++
 tb/tb_weyl_sng_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/weyl_sng_seq_if.sv
// Handshake and data bundle for weyl_sng_seq: operand input on one side,
// finished stochastic words and quotas on the other.
interface weyl_sng_seq_if #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8,
    parameter int CH        = 4
) ();
    logic                                     iValid;
    logic                                     oReady;
    logic [CH*QUANT-1:0]                      iData;
    logic                                     iMode;
    logic                                     oValid;
    logic                                     iReady;
    logic [CH*BITSTREAM-1:0]                  oBitstream;
    logic [CH*($clog2(BITSTREAM)+1)-1:0]      oQuota;

    modport master (
        output iValid, iData, iMode, iReady,
        input  oReady, oValid, oBitstream, oQuota
    );

    modport slave (
        input  iValid, iData, iMode, iReady,
        output oReady, oValid, oBitstream, oQuota
    );
endinterface

// File: rtl/weyl_sng_seq.sv
// Multi-channel sequential Weyl stochastic number generator: fills each
// channel's word LANES bits per cycle, then holds it on a valid/ready output.
module weyl_sng_seq #(
    parameter int BITSTREAM = 64,
    parameter int BASE      = 2,
    parameter int STRIDE    = 17,
    parameter int QUANT     = 8,
    parameter int CH        = 4,
    parameter int LANES     = 4,
    parameter int CH_OFFSET = 8
) (
    input logic           iClk,
    input logic           iRst_n,
    weyl_sng_seq_if.slave bus
);
    localparam int IW     = (BITSTREAM > 1) ? $clog2(BITSTREAM) : 1;
    localparam int SW     = $clog2(BITSTREAM) + 1;
    localparam int F      = (BITSTREAM + LANES - 1) / LANES;
    localparam int CW     = $clog2(F + 1);
    localparam int PW     = QUANT + SW + 1;
    localparam int STEP_W = STRIDE % BITSTREAM;
    localparam int STEP_T = 1 % BITSTREAM;
    localparam int ADV_W  = (LANES * STEP_W) % BITSTREAM;
    localparam int ADV_T  = (LANES * STEP_T) % BITSTREAM;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [CW-1:0]           fcnt_q, fcnt_d;
    logic [IW-1:0]           idx_q [CH];
    logic [IW-1:0]           idx_d [CH];
    logic [CH*BITSTREAM-1:0] bits_q, bits_d;
    logic [CH*SW-1:0]        quota_q, quota_d;

    // Offset-binary of q is exactly q + 2^(Q-1); round-half-up scale to 0..T.
    function automatic logic [SW-1:0] quota_of(input logic signed [QUANT-1:0] q);
        logic [QUANT-1:0] u;
        logic [PW-1:0]    prod;
        u    = {~q[QUANT-1], q[QUANT-2:0]};
        prod = PW'(u) * PW'(BITSTREAM) + PW'(2 ** (QUANT - 1));
        return SW'(prod >> QUANT);
    endfunction

    function automatic logic [IW-1:0] start_of(input int c);
        return IW'((BASE + c * CH_OFFSET) % BITSTREAM);
    endfunction

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            fcnt_q  <= '0;
            idx_q   <= '{default: '0};
            bits_q  <= '0;
            quota_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fcnt_q  <= fcnt_d;
            idx_q   <= idx_d;
            bits_q  <= bits_d;
            quota_q <= quota_d;
        end
    end

    always_comb begin
        int p;
        int n;
        int k;
        state_d = state_q;
        mode_d  = mode_q;
        fcnt_d  = fcnt_q;
        idx_d   = idx_q;
        bits_d  = bits_q;
        quota_d = quota_q;
        p       = 0;
        n       = 0;
        k       = int'(fcnt_q) * LANES;
        case (state_q)
            IDLE: begin
                if (bus.iValid) begin
                    state_d = FILL;
                    mode_d  = bus.iMode;
                    fcnt_d  = '0;
                    bits_d  = '0;
                    for (int c = 0; c < CH; c++) begin
                        quota_d[c*SW +: SW] = quota_of(bus.iData[c*QUANT +: QUANT]);
                        idx_d[c]            = bus.iMode ? '0 : start_of(c);
                    end
                end
            end
            FILL: begin
                // Lane l of this step covers sequence element k+l; bits only ever get set.
                for (int c = 0; c < CH; c++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (k + l < int'(quota_q[c*SW +: SW])) begin
                            p = int'(idx_q[c]) + (l * (mode_q ? STEP_T : STEP_W)) % BITSTREAM;
                            if (p >= BITSTREAM) p -= BITSTREAM;
                            bits_d[c*BITSTREAM + p] = 1'b1;
                        end
                    end
                    n = int'(idx_q[c]) + (mode_q ? ADV_T : ADV_W);
                    if (n >= BITSTREAM) n -= BITSTREAM;
                    idx_d[c] = IW'(n);
                end
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == CW'(F - 1)) state_d = DONE;
            end
            DONE: begin
                if (bus.iReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.oReady     = (state_q == IDLE);
    assign bus.oValid     = (state_q == DONE);
    assign bus.oBitstream = bits_q;
    assign bus.oQuota     = quota_q;
endmodule

// File: tb/tb_weyl_sng_seq.sv
// Directed self-checking bench for weyl_sng_seq at T=64, Q=8, CH=4, LANES=4.
module tb_weyl_sng_seq;
    localparam int T  = 64;
    localparam int Q  = 8;
    localparam int NC = 4;
    localparam int SW = 7;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [NC*T-1:0]  got_bits;
    logic [NC*SW-1:0] got_quota;

    always #5 clk = ~clk;

    weyl_sng_seq_if #(.BITSTREAM(T), .QUANT(Q), .CH(NC)) bus ();

    weyl_sng_seq #(
        .BITSTREAM(T), .BASE(2), .STRIDE(17), .QUANT(Q),
        .CH(NC), .LANES(4), .CH_OFFSET(8)
    ) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_quota(input int q);
        return ((q + 128) * 64 + 128) >> 8;
    endfunction

    function automatic logic [63:0] ref_word(input int q, input int c, input bit mode);
        int s, start, step;
        logic [63:0] w;
        s     = ref_quota(q);
        start = mode ? 0 : (2 + c * 8) % 64;
        step  = mode ? 1 : 17;
        w     = '0;
        for (int k = 0; k < s; k++) w[(start + k * step) % 64] = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.oReady && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("accept_ready", 64'(bus.oReady), 64'd1);
    endtask

    task automatic run_txn(input logic [31:0] data, input bit mode, input bit noise, input int hold);
        int lat, rdy_bad, unstable, q;
        logic [31:0] r;
        wait_ready();
        bus.iValid = 1'b1;
        bus.iData  = data;
        bus.iMode  = mode;
        @(posedge clk); #1;
        r          = $urandom;
        bus.iValid = 1'b0;
        bus.iData  = r;
        bus.iMode  = ~mode;
        lat = 0;
        rdy_bad = 0;
        while (!bus.oValid && lat < 100) begin
            if (bus.oReady) rdy_bad++;
            if (noise) begin
                r          = $urandom;
                bus.iValid = r[0];
                bus.iData  = $urandom;
            end
            @(posedge clk); #1; lat++;
        end
        bus.iValid = noise;
        check("latency", 64'(lat), 64'd16);
        check("ready_low_fill", 64'(rdy_bad), 64'd0);
        got_bits  = bus.oBitstream;
        got_quota = bus.oQuota;
        for (int c = 0; c < NC; c++) begin
            q = int'($signed(data[c*8 +: 8]));
            check($sformatf("word_ch%0d_q%0d", c, q), got_bits[c*T +: T], ref_word(q, c, mode));
            check($sformatf("quota_ch%0d_q%0d", c, q), 64'(got_quota[c*SW +: SW]), 64'(ref_quota(q)));
        end
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.oBitstream !== got_bits || bus.oQuota !== got_quota || !bus.oValid) unstable++;
        end
        if (hold > 0) check("hold_stable", 64'(unstable), 64'd0);
        bus.iReady = 1'b1;
        @(posedge clk); #1;
        bus.iReady = 1'b0;
        bus.iValid = 1'b0;
        check("valid_drop", 64'(bus.oValid), 64'd0);
        check("ready_return", 64'(bus.oReady), 64'd1);
    endtask

    initial begin
        logic [63:0] w0;
        logic [31:0] r;
        rst_n      = 1'b0;
        bus.iValid = 1'b0;
        bus.iData  = '0;
        bus.iMode  = 1'b0;
        bus.iReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", 64'(bus.oReady), 64'd1);
        check("rst_valid", 64'(bus.oValid), 64'd0);
        check("rst_bits", 64'(bus.oBitstream != '0), 64'd0);
        check("rst_quota", 64'(bus.oQuota), 64'd0);

        // Extremes
        run_txn(pack4(-128, -128, -128, -128), 1'b0, 1'b0, 0);
        check("min_ch0", got_bits[63:0], 64'h0);
        check("min_ch3", got_bits[255:192], 64'h0);
        check("min_quota0", 64'(got_quota[6:0]), 64'd0);
        run_txn(pack4(127, 127, 127, 127), 1'b0, 1'b0, 0);
        for (int c = 0; c < NC; c++)
            check($sformatf("max_ch%0d", c), got_bits[c*T +: T], 64'hFFFF_FFFF_FFFF_FFFF);
        check("max_quota2", 64'(got_quota[20:14]), 64'd64);

        // Midpoint and channel skew
        run_txn(pack4(0, 0, 0, 0), 1'b0, 1'b0, 0);
        for (int c = 0; c < NC; c++)
            check($sformatf("mid_pop_ch%0d", c), 64'($countones(got_bits[c*T +: T])), 64'd32);
        w0 = got_bits[63:0];
        check("mid_ch0_bits", 64'({w0[2], w0[19], w0[36], w0[53], w0[6]}), 64'h1f);
        w0 = got_bits[127:64];
        check("mid_ch1_bits", 64'({w0[10], w0[27], w0[44], w0[2]}), 64'he);
        w0 = got_bits[255:192];
        check("mid_ch3_start", 64'(w0[26]), 64'd1);
        check("mid_quota1", 64'(got_quota[13:7]), 64'd32);

        // Rounding boundary
        run_txn(pack4(-127, -127, -127, -127), 1'b0, 1'b0, 0);
        check("m127_ch0", got_bits[63:0], 64'h0);
        check("m127_quota", 64'(got_quota[6:0]), 64'd0);
        run_txn(pack4(-126, -126, -126, -126), 1'b0, 1'b0, 0);
        check("m126_ch0", got_bits[63:0], 64'h4);
        check("m126_ch1", got_bits[127:64], 64'h400);
        check("m126_quota", 64'(got_quota[6:0]), 64'd1);

        // Thermometer mode
        run_txn(pack4(0, 0, 0, 0), 1'b1, 1'b0, 0);
        for (int c = 0; c < NC; c++)
            check($sformatf("therm_ch%0d", c), got_bits[c*T +: T], 64'h0000_0000_FFFF_FFFF);

        // Sweep ch0 with random neighbours
        for (int q = -128; q <= 127; q++) begin
            r = $urandom;
            run_txn({r[31:8], 8'(q)}, 1'b0, 1'b0, 0);
        end

        // Backpressure with iValid noise during fill and hold
        run_txn(pack4(5, -60, 90, -3), 1'b0, 1'b1, 5);

        // Reset mid-fill
        wait_ready();
        bus.iValid = 1'b1;
        bus.iData  = pack4(127, 127, 127, 127);
        bus.iMode  = 1'b0;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("partial_pop", 64'($countones(bus.oBitstream[63:0])), 64'd24);
        check("partial_valid", 64'(bus.oValid), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_valid", 64'(bus.oValid), 64'd0);
        check("abort_ready", 64'(bus.oReady), 64'd1);
        check("abort_bits", 64'(bus.oBitstream != '0), 64'd0);
        check("abort_quota", 64'(bus.oQuota), 64'd0);
        run_txn(pack4(0, -126, 127, -128), 1'b0, 1'b0, 0);
        check("post_rst_pop0", 64'($countones(got_bits[63:0])), 64'd32);
        check("post_rst_ch1", got_bits[127:64], 64'h400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end
endmodule
